// File: rtl/gts_pkg.sv
// Shared definitions for the gate truth-table self-test sequencer:
// state encoding, vector count and error counter width.
package gts_pkg;

    localparam logic [1:0] GTS_IDLE   = 2'd0;
    localparam logic [1:0] GTS_DRIVE  = 2'd1;
    localparam logic [1:0] GTS_SAMPLE = 2'd2;
    localparam logic [1:0] GTS_DONE   = 2'd3;

    // A 2-input gate has exactly four input vectors, indexed {in1,in0}.
    localparam int GTS_NUM_VEC = 4;

    // Error counter must hold 0..GTS_NUM_VEC inclusive.
    localparam int GTS_ERR_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = GTS_IDLE,
        ST_DRIVE  = GTS_DRIVE,
        ST_SAMPLE = GTS_SAMPLE,
        ST_DONE   = GTS_DONE
    } gts_state_e;

endpackage

// File: rtl/gate_truth_sequencer_if.sv
// Bundle of the sequencer's harness-side and gate-side signals.
// Optional fail capture outputs exist only when GTS_FAIL_CAPTURE_EN is defined.
//
// Handshake: start is a level request with no ready/ack; it is sampled only
// while the sequencer is in IDLE or DONE (busy=0). A start seen while busy=1
// is dropped, not queued. done stays high until the next accepted start or
// reset, and pass/err_cnt are valid whenever done=1.
interface gate_truth_sequencer_if;

    logic                          start;
    logic                          in0;
    logic                          in1;
    logic                          out;
    logic                          busy;
    logic                          done;
    logic                          pass;
    logic [gts_pkg::GTS_ERR_W-1:0] err_cnt;
    logic [1:0]                    dbg_state;
`ifdef GTS_FAIL_CAPTURE_EN
    logic [1:0]                    fail_vec;
    logic                          fail_vld;

    modport slave (
        input  start, out,
        output in0, in1, busy, done, pass, err_cnt, dbg_state, fail_vec, fail_vld
    );

    modport master (
        output start, out,
        input  in0, in1, busy, done, pass, err_cnt, dbg_state, fail_vec, fail_vld
    );
`else
    modport slave (
        input  start, out,
        output in0, in1, busy, done, pass, err_cnt, dbg_state
    );

    modport master (
        output start, out,
        input  in0, in1, busy, done, pass, err_cnt, dbg_state
    );
`endif

endinterface

// File: rtl/gate_truth_sequencer.sv
// Self-test controller for a 2-input, 1-output gate. Walks {in1,in0} through
// 00,01,10,11, holds each vector SETTLE_CYCLES cycles, samples the gate output
// on one extra cycle and counts mismatches against the EXPECT truth table.
// Optional feature macro: GTS_FAIL_CAPTURE_EN (records the first failing vector).
module gate_truth_sequencer
    import gts_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [3:0]  EXPECT        = 4'b0010
) (
    input  logic                  clk,
    input  logic                  rst,
    gate_truth_sequencer_if.slave bus
);

    // Settle counter only needs to reach SETTLE_CYCLES-1.
    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [1:0] VEC_LAST = 2'(GTS_NUM_VEC - 1);
    localparam logic [GTS_ERR_W-1:0] ERR_MAX = GTS_ERR_W'(GTS_NUM_VEC);

    if (SETTLE_CYCLES == 0) begin : g_settle_check
        $error("gate_truth_sequencer: SETTLE_CYCLES must be >= 1");
    end

    gts_state_e           r_state;
    gts_state_e           w_state_nxt;
    logic [1:0]           r_vec;
    logic [1:0]           w_vec_nxt;
    logic [1:0]           w_stim_nxt;
    logic [SW-1:0]        r_settle;
    logic [GTS_ERR_W-1:0] r_err_cnt;
    logic                 r_in0;
    logic                 r_in1;
    logic                 w_run_start;
    logic                 w_mismatch;
    logic                 w_vec_last;
    logic                 w_settle_last;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, next-vector and sample-compare decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_run_start   = 1'b0;
        w_vec_last    = (r_vec == VEC_LAST);
        w_settle_last = (r_settle == SETTLE_LAST);
        // X/Z from the gate counts as a mismatch, hence the 4-state compare.
        w_mismatch    = (r_state == ST_SAMPLE) && (bus.out !== EXPECT[r_vec]);

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    w_state_nxt = ST_DRIVE;
                    w_run_start = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (w_settle_last) begin
                    w_state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                w_state_nxt = w_vec_last ? ST_DONE : ST_DRIVE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_vec_nxt = r_vec;
        if (w_run_start) begin
            w_vec_nxt = 2'd0;
        end else if ((r_state == ST_SAMPLE) && !w_vec_last) begin
            w_vec_nxt = r_vec + 2'd1;
        end

        // Stimulus follows the vector while a run is active, else parks at 00.
        w_stim_nxt = 2'b00;
        if ((w_state_nxt == ST_DRIVE) || (w_state_nxt == ST_SAMPLE)) begin
            w_stim_nxt = w_vec_nxt;
        end
    end

    // Datapath: vector index, registered stimulus, settle counter, error count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec     <= 2'd0;
            r_in0     <= 1'b0;
            r_in1     <= 1'b0;
            r_settle  <= '0;
            r_err_cnt <= '0;
        end else begin
            r_vec <= w_vec_nxt;
            r_in0 <= w_stim_nxt[0];
            r_in1 <= w_stim_nxt[1];

            // Counts DRIVE cycles; zero everywhere else so each vector starts fresh.
            if ((r_state == ST_DRIVE) && !w_settle_last) begin
                r_settle <= r_settle + 1'b1;
            end else begin
                r_settle <= '0;
            end

            if (w_run_start) begin
                r_err_cnt <= '0;
            end else if (w_mismatch && (r_err_cnt != ERR_MAX)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

`ifdef GTS_FAIL_CAPTURE_EN
    logic [1:0] r_fail_vec;
    logic       r_fail_vld;

    // Latch the first failing vector of a run; later mismatches leave it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fail_vec <= 2'd0;
            r_fail_vld <= 1'b0;
        end else if (w_run_start) begin
            r_fail_vec <= 2'd0;
            r_fail_vld <= 1'b0;
        end else if (w_mismatch && !r_fail_vld) begin
            r_fail_vec <= r_vec;
            r_fail_vld <= 1'b1;
        end
    end

    assign bus.fail_vec = r_fail_vec;
    assign bus.fail_vld = r_fail_vld;
`endif

    assign bus.in0       = r_in0;
    assign bus.in1       = r_in1;
    assign bus.busy      = (r_state == ST_DRIVE) || (r_state == ST_SAMPLE);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.pass      = (r_state == ST_DONE) && (r_err_cnt == '0);
    assign bus.err_cnt   = r_err_cnt;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Bench for gate_truth_sequencer: two instances (SETTLE_CYCLES=2 and =1)
// driving a truth-table gate model, directed table runs, abort sequences
// and randomized gates checked against a truth-table reference model.
module tb_gate_truth_sequencer;

    localparam int S0 = 2;
    localparam int S1 = 1;
    localparam logic [3:0] EXP_TT = 4'b0010;  // SECOND_TICK: out = in0 & ~in1

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] gate_tt;
    int         dut_sel;
    int         checks;
    int         errors;

    gate_truth_sequencer_if gif0();
    gate_truth_sequencer_if gif1();

    // Gate under test: arbitrary 2-input function given as a truth table.
    assign gif0.start = start;
    assign gif1.start = start;
    assign gif0.out   = gate_tt[{gif0.in1, gif0.in0}];
    assign gif1.out   = gate_tt[{gif1.in1, gif1.in0}];

    gate_truth_sequencer #(.SETTLE_CYCLES(S0), .EXPECT(EXP_TT)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (gif0)
    );

    gate_truth_sequencer #(.SETTLE_CYCLES(S1), .EXPECT(EXP_TT)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (gif1)
    );

    // Observed instance selected by dut_sel.
    logic       obs_in0, obs_in1, obs_busy, obs_done, obs_pass;
    logic [2:0] obs_err;
    logic [1:0] obs_state;
    logic [1:0] obs_fail_vec;
    logic       obs_fail_vld;

    always_comb begin
        obs_in0      = gif0.in0;
        obs_in1      = gif0.in1;
        obs_busy     = gif0.busy;
        obs_done     = gif0.done;
        obs_pass     = gif0.pass;
        obs_err      = gif0.err_cnt;
        obs_state    = gif0.dbg_state;
        obs_fail_vec = 2'd0;
        obs_fail_vld = 1'b0;
`ifdef GTS_FAIL_CAPTURE_EN
        obs_fail_vec = gif0.fail_vec;
        obs_fail_vld = gif0.fail_vld;
`endif
        if (dut_sel == 1) begin
            obs_in0   = gif1.in0;
            obs_in1   = gif1.in1;
            obs_busy  = gif1.busy;
            obs_done  = gif1.done;
            obs_pass  = gif1.pass;
            obs_err   = gif1.err_cnt;
            obs_state = gif1.dbg_state;
`ifdef GTS_FAIL_CAPTURE_EN
            obs_fail_vec = gif1.fail_vec;
            obs_fail_vld = gif1.fail_vld;
`endif
        end
    end

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: error count and first failing vector from the truth tables.
    function automatic int model_err(input logic [3:0] tt);
        int n = 0;
        for (int v = 0; v < 4; v++) begin
            if (tt[v] != EXP_TT[v]) n++;
        end
        return n;
    endfunction

    function automatic logic [1:0] model_first(input logic [3:0] tt);
        for (int v = 3; v >= 0; v--) begin
            if (tt[v] != EXP_TT[v]) model_first = 2'(v);
        end
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_in0"}, obs_in0, 0);
        chk({tag, "_in1"}, obs_in1, 0);
        chk({tag, "_busy"}, obs_busy, 0);
        chk({tag, "_done"}, obs_done, 0);
        chk({tag, "_pass"}, obs_pass, 0);
        chk({tag, "_err"}, obs_err, 0);
        chk({tag, "_state"}, obs_state, 0);
`ifdef GTS_FAIL_CAPTURE_EN
        chk({tag, "_fvec"}, obs_fail_vec, 0);
        chk({tag, "_fvld"}, obs_fail_vld, 0);
`endif
    endtask

    // Both instances idle or done before a run; bounded wait.
    task automatic wait_quiet();
        int n = 0;
        while ((gif0.busy || gif1.busy) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("quiet", {31'd0, !(gif0.busy || gif1.busy)}, 1);
    endtask

    // One full run on the selected instance; extra_idx >= 0 pulses start mid-run.
    task automatic run_check(input int sel, input logic [3:0] tt, input int exp_err,
                             input logic [1:0] exp_fv, input int extra_idx);
        int hold;
        int len;
        dut_sel = sel;
        gate_tt = tt;
        hold = (sel == 0) ? S0 + 1 : S1 + 1;
        len  = 4 * hold;
        wait_quiet();
        start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < len; i++) begin
            start = (i == extra_idx);
            chk("stim", {obs_in1, obs_in0}, i / hold);
            chk("busy_run", obs_busy, 1);
            chk("done_run", obs_done, 0);
            if (i == 0) begin
                chk("err_clr", obs_err, 0);
`ifdef GTS_FAIL_CAPTURE_EN
                chk("fvld_clr", obs_fail_vld, 0);
`endif
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_end", obs_done, 1);
        chk("busy_end", obs_busy, 0);
        chk("stim_end", {obs_in1, obs_in0}, 0);
        chk("state_end", obs_state, 3);
        chk("err_end", obs_err, exp_err);
        chk("pass_end", obs_pass, (exp_err == 0));
`ifdef GTS_FAIL_CAPTURE_EN
        chk("fvld_end", obs_fail_vld, (exp_err != 0));
        if (exp_err != 0) chk("fvec_end", obs_fail_vec, exp_fv);
`endif
        @(negedge clk);
        chk("done_hold", obs_done, 1);
    endtask

    typedef struct {
        logic [3:0] tt;
        int         exp_err;
        logic [1:0] exp_fv;
        int         extra;
        int         sel;
    } vec_t;

    vec_t tbl[8];

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        start   = 1'b0;
        gate_tt = EXP_TT;
        dut_sel = 0;

        tbl[0] = '{4'b0010, 0, 2'd0, -1, 0};  // SECOND_TICK gate
        tbl[1] = '{4'b0110, 1, 2'd2, -1, 0};  // XOR gate
        tbl[2] = '{4'b1111, 3, 2'd0, -1, 0};  // output tied 1
        tbl[3] = '{4'b0000, 1, 2'd1, -1, 0};  // output tied 0
        tbl[4] = '{4'b1101, 4, 2'd0, -1, 0};  // every vector wrong
        tbl[5] = '{4'b0010, 0, 2'd0,  3, 0};  // start during DRIVE of vec 1
        tbl[6] = '{4'b0010, 0, 2'd0, -1, 1};  // SETTLE_CYCLES=1 build
        tbl[7] = '{4'b0110, 1, 2'd2,  2, 1};  // SETTLE_CYCLES=1, start while busy

        // Reset.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("rst_hold");
        rst = 1'b0;
        @(negedge clk);
        check_reset("rst_rel");
        dut_sel = 1;
        check_reset("rst_rel1");
        dut_sel = 0;

        // Directed table.
        for (int k = 0; k < 8; k++) begin
            run_check(tbl[k].sel, tbl[k].tt, tbl[k].exp_err, tbl[k].exp_fv, tbl[k].extra);
        end

        // Abort in SAMPLE of vec 2, then rst together with start.
        dut_sel = 0;
        gate_tt = 4'b1111;
        wait_quiet();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2 * (S0 + 1) + S0) @(negedge clk);
        chk("abort_pre_state", obs_state, 2);
        chk("abort_pre_stim", {obs_in1, obs_in0}, 2);
        rst = 1'b1;
        @(negedge clk);
        check_reset("abort");
        start = 1'b1;
        @(negedge clk);
        check_reset("rst_start");
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_reset("post_abort");

        // Randomized gates against the reference model.
        for (int k = 0; k < 24; k++) begin
            logic [3:0] tt;
            int sel;
            int len;
            int extra;
            tt    = 4'($urandom_range(0, 15));
            sel   = $urandom_range(0, 1);
            len   = 4 * ((sel == 0) ? S0 + 1 : S1 + 1);
            extra = ($urandom_range(0, 1) == 1) ? $urandom_range(0, len - 1) : -1;
            run_check(sel, tt, model_err(tt), model_first(tt), extra);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
